// File: rtl/qick_div_pipe.sv
// qick_div_pipe: fully pipelined restoring integer divider, signed or unsigned per operation.
// Pipeline: stage-0 input register, N_PIPE restoring stages, registered output stage.
module qick_div_pipe #(
    parameter int DW        = 32,
    parameter int N_PIPE    = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          signed_i,
    input  logic [DW-1:0] A_i,
    input  logic [DW-1:0] B_i,
    output logic          ready_o,
    output logic          busy_o,
    output logic          valid_o,
    output logic [DW-1:0] div_quotient_o,
    output logic [DW-1:0] div_remainder_o,
    output logic          div_zero_o
);
    localparam int BPS = DW / N_PIPE;
    localparam int NS  = N_PIPE + 1;

    logic [NS-1:0] vld_q;
    logic [NS-1:0] negq_q;
    logic [NS-1:0] negr_q;
    logic [NS-1:0] dz_q;
    logic [DW-1:0] rem_q [NS];
    logic [DW-1:0] rem_d [NS];
    logic [DW-1:0] quo_q [NS];
    logic [DW-1:0] quo_d [NS];
    logic [DW-1:0] dvs_q [NS];
    logic [DW-1:0] a_q   [NS];
    logic [DW-1:0] dvs0_d;

    logic            sgn;
    logic [2*DW-1:0] r_wide;
    logic [2*DW-1:0] d_shift;
    logic [DW-1:0]   q_work;
    int              bit_idx;

    logic            valid_q;
    logic            dz_o_q;
    logic            dz_o_d;
    logic [DW-1:0]   quo_o_q;
    logic [DW-1:0]   quo_o_d;
    logic [DW-1:0]   rem_o_q;
    logic [DW-1:0]   rem_o_d;

    always_comb begin
        sgn      = SIGNED_EN ? signed_i : 1'b0;
        rem_d[0] = (sgn && A_i[DW-1]) ? -A_i : A_i;
        quo_d[0] = '0;
        dvs0_d   = (sgn && B_i[DW-1]) ? -B_i : B_i;
        r_wide   = '0;
        d_shift  = '0;
        q_work   = '0;
        bit_idx  = 0;
        // The remainder never exceeds |A|, so DW bits hold it; only the compare needs 2*DW.
        for (int k = 1; k < NS; k++) begin
            r_wide = {{DW{1'b0}}, rem_q[k-1]};
            q_work = quo_q[k-1];
            for (int j = 0; j < BPS; j++) begin
                bit_idx = DW - 1 - (k - 1) * BPS - j;
                d_shift = {{DW{1'b0}}, dvs_q[k-1]} << bit_idx;
                if (r_wide >= d_shift) begin
                    r_wide = r_wide - d_shift;
                    q_work = q_work | (DW'(1) << bit_idx);
                end
            end
            rem_d[k] = r_wide[DW-1:0];
            quo_d[k] = q_work;
        end
    end

    always_comb begin
        dz_o_d = dz_q[N_PIPE];
        if (dz_q[N_PIPE]) begin
            quo_o_d = '1;
            rem_o_d = a_q[N_PIPE];
        end else begin
            quo_o_d = negq_q[N_PIPE] ? -quo_q[N_PIPE] : quo_q[N_PIPE];
            rem_o_d = negr_q[N_PIPE] ? -rem_q[N_PIPE] : rem_q[N_PIPE];
        end
    end

    // Datapath registers carry no reset; the valid bits alone qualify them.
    always_ff @(posedge clk_i) begin
        rem_q[0]  <= rem_d[0];
        quo_q[0]  <= quo_d[0];
        dvs_q[0]  <= dvs0_d;
        a_q[0]    <= A_i;
        negq_q[0] <= sgn & (A_i[DW-1] ^ B_i[DW-1]);
        negr_q[0] <= sgn & A_i[DW-1];
        dz_q[0]   <= (B_i == '0);
        for (int k = 1; k < NS; k++) begin
            rem_q[k]  <= rem_d[k];
            quo_q[k]  <= quo_d[k];
            dvs_q[k]  <= dvs_q[k-1];
            a_q[k]    <= a_q[k-1];
            negq_q[k] <= negq_q[k-1];
            negr_q[k] <= negr_q[k-1];
            dz_q[k]   <= dz_q[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q   <= '0;
            valid_q <= 1'b0;
            dz_o_q  <= 1'b0;
            quo_o_q <= '0;
            rem_o_q <= '0;
        end else begin
            vld_q   <= {vld_q[NS-2:0], start_i};
            valid_q <= vld_q[N_PIPE];
            if (vld_q[N_PIPE]) begin
                dz_o_q  <= dz_o_d;
                quo_o_q <= quo_o_d;
                rem_o_q <= rem_o_d;
            end
        end
    end

    assign ready_o         = ~rst_i;
    assign busy_o          = (|vld_q) | valid_q;
    assign valid_o         = valid_q;
    assign div_quotient_o  = quo_o_q;
    assign div_remainder_o = rem_o_q;
    assign div_zero_o      = dz_o_q;

endmodule

// File: tb/tb_qick_div_pipe.sv
// Bench for qick_div_pipe: five configurations share one stimulus stream and are checked
// every cycle against an arithmetic reference model with per-configuration result queues.
module tb_qick_div_pipe;
    typedef struct packed {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } res_t;

    localparam int ND = 5;
    localparam int RB = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sgn = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic [ND-1:0] rdy, bsy, vld, dz;
    logic [31:0]   quo32 [4];
    logic [31:0]   rem32 [4];
    logic [15:0]   quo16, rem16;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   lat [ND] = '{9, 2, 5, 33, 5};
    int   dwv [ND] = '{32, 32, 32, 32, 16};
    int   e_due [ND][RB];
    res_t e_res [ND][RB];
    int   hd [ND] = '{0, 0, 0, 0, 0};
    int   tl [ND] = '{0, 0, 0, 0, 0};
    int   last_due0 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_d32
        localparam int NP = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
        qick_div_pipe #(.DW(32), .N_PIPE(NP), .SIGNED_EN(1'b1)) u_dut (
            .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn),
            .A_i(a), .B_i(b), .ready_o(rdy[g]), .busy_o(bsy[g]), .valid_o(vld[g]),
            .div_quotient_o(quo32[g]), .div_remainder_o(rem32[g]), .div_zero_o(dz[g])
        );
    end

    qick_div_pipe #(.DW(16), .N_PIPE(4), .SIGNED_EN(1'b1)) u_dut16 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .signed_i(sgn),
        .A_i(a[15:0]), .B_i(b[15:0]), .ready_o(rdy[4]), .busy_o(bsy[4]), .valid_o(vld[4]),
        .div_quotient_o(quo16), .div_remainder_o(rem16), .div_zero_o(dz[4])
    );

    function automatic logic [31:0] get_q(input int i);
        return (i == 4) ? {16'h0, quo16} : quo32[i];
    endfunction

    function automatic logic [31:0] get_r(input int i);
        return (i == 4) ? {16'h0, rem16} : rem32[i];
    endfunction

    // Reference: plain integer division, truncating toward zero.
    function automatic res_t model(input logic [31:0] ai, input logic [31:0] bi,
                                   input logic s, input int w);
        res_t   res;
        longint mask, ua, ub, sa, sb, qq, rr;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(ai) & mask;
        ub   = longint'(bi) & mask;
        if (ub == 0) begin
            res.q = 32'(mask);
            res.r = 32'(ua);
            res.z = 1'b1;
            return res;
        end
        if (s) begin
            sa = ua[w-1] ? ua - (longint'(1) << w) : ua;
            sb = ub[w-1] ? ub - (longint'(1) << w) : ub;
            qq = sa / sb;
            rr = sa % sb;
        end else begin
            qq = ua / ub;
            rr = ua % ub;
        end
        res.q = 32'(qq & mask);
        res.r = 32'(rr & mask);
        res.z = 1'b0;
        return res;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < ND; i++) if (hd[i] != tl[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (vld[i]) begin
                checks++;
                if (hd[i] == tl[i] || e_due[i][hd[i] % RB] != cyc) begin
                    failures++;
                    $display("FAIL unexpected_valid dut=%0d cyc=%0d got valid_o=1 required 0", i, cyc);
                end else begin
                    res_t e;
                    e = e_res[i][hd[i] % RB];
                    hd[i]++;
                    if (get_q(i) != e.q || get_r(i) != e.r || dz[i] != e.z) begin
                        failures++;
                        $display("FAIL result dut=%0d cyc=%0d got q=%h r=%h z=%b required q=%h r=%h z=%b",
                                 i, cyc, get_q(i), get_r(i), dz[i], e.q, e.r, e.z);
                    end
                end
            end else if (hd[i] != tl[i] && e_due[i][hd[i] % RB] <= cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_valid dut=%0d cyc=%0d got valid_o=0 required 1", i, cyc);
                hd[i]++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    // Called at a negedge; the operation is sampled at the next rising edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic s);
        a = av; b = bv; sgn = s; start = 1'b1;
        for (int i = 0; i < ND; i++) begin
            e_due[i][tl[i] % RB] = cyc + 1 + lat[i];
            e_res[i][tl[i] % RB] = model(av, bv, s, dwv[i]);
            tl[i]++;
        end
        last_due0 = cyc + 1 + lat[0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic lit(input logic [31:0] av, input logic [31:0] bv, input logic s,
                       input logic [31:0] eq, input logic [31:0] er, input logic ez);
        res_t m;
        m = model(av, bv, s, 32);
        check("model_q", m.q, eq);
        check("model_r", m.r, er);
        check("model_z", {31'b0, m.z}, {31'b0, ez});
        issue(av, bv, s);
    endtask

    task automatic drain();
        int n = 0;
        while (!all_empty() && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!all_empty()) begin
            failures++;
            $display("FAIL drain_timeout got pending results required none");
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        for (int i = 0; i < ND; i++)
            while (tl[i] > hd[i] && e_due[i][(tl[i] - 1) % RB] >= cyc + 1) tl[i]--;
        @(negedge clk);
        check("rst_busy", {27'b0, bsy}, 32'h0);
        check("rst_valid", {27'b0, vld}, 32'h0);
        check("rst_ready", {27'b0, rdy}, 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_ready", {27'b0, rdy}, 32'h0);
        check("reset_busy", {27'b0, bsy}, 32'h0);
        check("reset_valid", {27'b0, vld}, 32'h0);
        check("reset_dz", {27'b0, dz}, 32'h0);
        check("reset_q0", quo32[0], 32'h0);
        check("reset_r0", rem32[0], 32'h0);
        // Issue while in reset must be ignored; no model entry is pushed.
        a = 32'd50; b = 32'd5; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        #1;
        check("ready_after_reset", {27'b0, rdy}, 32'h1f);
        @(negedge clk);

        lit(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        lit(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        lit(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
        lit(32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
        lit(32'h12345678, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b1);
        lit(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
        lit(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0);
        drain();

        for (int n = 0; n < 20; n++) begin
            logic [31:0] av, bv;
            av = (n == 5) ? 32'h80000000 : $urandom();
            bv = (n % 7 == 3) ? 32'd0 : ($urandom() >> $urandom_range(0, 31));
            a = av; b = bv; sgn = 1'($urandom_range(0, 1));
            for (int i = 0; i < ND; i++) begin
                e_due[i][tl[i] % RB] = cyc + 1 + lat[i];
                e_res[i][tl[i] % RB] = model(av, bv, sgn, dwv[i]);
                tl[i]++;
            end
            last_due0 = cyc + 1 + lat[0];
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        while (cyc < last_due0) @(negedge clk);
        check("busy_last_pulse", {31'b0, bsy[0]}, 32'h1);
        @(negedge clk);
        check("busy_after_last", {31'b0, bsy[0]}, 32'h0);
        drain();

        issue(32'd1000, 32'd3, 1'b0);
        issue(32'hFFFFFC18, 32'd3, 1'b1);
        issue(32'd77, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        pulse_reset();
        issue(32'd12345, 32'd67, 1'b0);
        drain();
        check("idle_busy", {27'b0, bsy}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
